serial_tx_piso: RTL and testbench

- Parallel-in, serial-out transmitter. Pair block for the 8-bit serial-in shift register: it produces the MSB-first bit stream that the shift register consumes on its serial input.
- Accepts parallel words over a valid/ready handshake. Shifts each word out MSB first, one bit per enabled clock.
- A one-entry holding buffer lets consecutive words stream with no idle gap between frames.

---
 rtl/serial_tx_piso.sv | 100 ++++++++++
 tb/tb_serial_tx_piso.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_piso.sv
// rtl/serial_tx_piso.sv - MSB-first parallel-in serial-out transmitter
// One-entry holding buffer lets back-to-back words stream with no idle gap.
module serial_tx_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            fsm_q, fsm_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              accept;
    logic              last_edge;

    assign accept    = in_valid & ~buf_full_q;
    assign last_edge = (fsm_q == SHIFT) & shift_en & (cnt_q == LAST);

    always_comb begin
        fsm_d      = fsm_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
                    fsm_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_q != LAST) begin
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q + CW'(1);
                    end else if (buf_full_q) begin
                        shreg_d    = buf_q;
                        buf_full_d = 1'b0;
                        cnt_d      = '0;
                    end else if (in_valid) begin
                        // Bypass: the word goes straight to the shifter, not the buffer.
                        shreg_d = in_data;
                        cnt_d   = '0;
                    end else begin
                        fsm_d = IDLE;
                        cnt_d = '0;
                    end
                end
                if (accept && !last_edge) begin
                    buf_d      = in_data;
                    buf_full_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign in_ready    = ~buf_full_q;
    assign sout_valid  = (fsm_q == SHIFT);
    assign sout        = sout_valid & shreg_q[WIDTH-1];
    assign frame_start = (fsm_q == SHIFT) & (cnt_q == '0);
    assign busy        = (fsm_q == SHIFT) | buf_full_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// tb/tb_serial_tx_piso.sv - directed bench for serial_tx_piso
module tb_serial_tx_piso;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       shift_en;
    logic       sout;
    logic       sout_valid;
    logic       frame_start;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] bits;
    int          nbits;
    int          fs_idx[$];

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       se;
        logic [4:0] exp; // {sout, sout_valid, frame_start, busy, in_ready}
    } vec_t;

    vec_t vecs[$];

    serial_tx_piso #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_start(frame_start),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic iv, input logic [7:0] d, input logic se,
                                input logic [4:0] exp);
        vec_t v;
        v.iv = iv; v.d = d; v.se = se; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bits  = '0;
        nbits = 0;
        fs_idx.delete();
    endtask

    task automatic sample();
        if (sout_valid) begin
            if (frame_start) fs_idx.push_back(nbits);
            bits = {bits[62:0], sout};
            nbits++;
        end else if (sout !== 1'b0) begin
            chk("sout_forced_zero", 64'(sout), 64'd0);
        end
    endtask

    task automatic drain(input int bound, input string name);
        int n;
        n = 0;
        while (sout_valid && n < bound) begin
            tick();
            sample();
            n++;
        end
        if (n >= bound) chk({name, "_timeout"}, 64'(n), 64'(bound - 1));
    endtask

    initial begin
        logic [7:0] w;
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        shift_en = 1'b0;

        // single word 0xA5
        w = 8'hA5;
        add(1'b0, 8'h00, 1'b0, 5'b00001);
        add(1'b1, w, 1'b1, 5'b11111);
        for (int i = 1; i < 8; i++) add(1'b0, 8'h00, 1'b1, {w[7-i], 4'b1011});
        add(1'b0, 8'h00, 1'b1, 5'b00001);
        // bypass at the last bit: 0x00 then 0xFF with no gap
        add(1'b1, 8'h00, 1'b1, 5'b01111);
        for (int i = 1; i < 8; i++) add(1'b0, 8'h00, 1'b1, 5'b01011);
        add(1'b1, 8'hFF, 1'b1, 5'b11111);
        for (int i = 1; i < 8; i++) add(1'b0, 8'h00, 1'b1, 5'b11011);
        add(1'b0, 8'h00, 1'b1, 5'b00001);

        #12;
        chk("reset_outputs", 64'({sout, sout_valid, frame_start, busy, in_ready}), 64'b00001);
        @(negedge clk);
        rst = 1'b1;
        tick();

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv;
            in_data  = vecs[i].d;
            shift_en = vecs[i].se;
            tick();
            chk($sformatf("vec%0d", i),
                64'({sout, sout_valid, frame_start, busy, in_ready}), 64'(vecs[i].exp));
        end
        in_valid = 1'b0;

        // back-to-back: 0x3C offered during bit 2 of 0xA5
        clr();
        in_valid = 1'b1; in_data = 8'hA5; shift_en = 1'b1;
        tick(); sample();
        in_valid = 1'b0;
        tick(); sample();
        tick(); sample();
        in_valid = 1'b1; in_data = 8'h3C;
        tick(); sample();
        chk("b2b_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        drain(40, "b2b");
        chk("b2b_nbits", 64'(nbits), 64'd16);
        chk("b2b_stream", bits[15:0], 64'hA53C);
        chk("b2b_fs_count", 64'(fs_idx.size()), 64'd2);
        if (fs_idx.size() == 2) chk("b2b_fs_pos", 64'({fs_idx[0], fs_idx[1]}), {32'd0, 32'd8});
        chk("b2b_idle_busy", 64'(busy), 64'd0);

        // pacing: shift_en one cycle in four, 0x81
        clr();
        in_valid = 1'b1; in_data = 8'h81; shift_en = 1'b0;
        tick(); sample();
        in_valid = 1'b0;
        for (int c = 0; c < 200 && sout_valid; c++) begin
            shift_en = (c % 4 == 3);
            tick();
            sample();
        end
        chk("pace_nbits", 64'(nbits), 64'd32);
        chk("pace_stream", bits[31:0], 64'hF000000F);
        chk("pace_fs_cycles", 64'(fs_idx.size()), 64'd4);

        // backpressure: a new word offered every cycle of the first frame
        clr();
        shift_en = 1'b1;
        in_valid = 1'b1; in_data = 8'h11;
        tick(); sample();
        for (int i = 0; i < 7; i++) begin
            in_data = 8'h22 + 8'(i * 8'h11);
            tick(); sample();
            if (i == 0) chk("bp_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        drain(40, "bp");
        chk("bp_nbits", 64'(nbits), 64'd16);
        chk("bp_stream", bits[15:0], 64'h1122);

        // reset mid-frame with a buffered word
        clr();
        in_valid = 1'b1; in_data = 8'hC3;
        tick();
        in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("rst_pre_busy", 64'({busy, in_ready}), 64'b10);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_outputs",
            64'({sout, sout_valid, frame_start, busy, in_ready}), 64'b00001);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            sample();
        end
        chk("rst_no_bits", 64'(nbits), 64'd0);
        chk("rst_idle_busy", 64'({busy, in_ready}), 64'b01);
        in_valid = 1'b1; in_data = 8'h80;
        tick();
        in_valid = 1'b0;
        chk("rst_restart", 64'({sout, sout_valid, frame_start}), 64'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
